// File: rtl/rsa_plain_feeder.sv
// Plaintext feeder for the RSA core: a small FIFO of CPU words dispatched one job at a time.
// It holds plaint for the whole job, counts completions, and uses a watchdog to abandon a stuck core.
module rsa_plain_feeder #(
    parameter int DW      = 32,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic [DW-1:0]          wr_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level,
    output logic [DW-1:0]          plaint,
    output logic                   in_vaild,
    input  logic                   ready,
    input  logic                   vaild,
    output logic                   busy,
    output logic [15:0]            done_cnt,
    output logic                   timeout_err,
    output logic                   ovf_err,
    input  logic                   err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] WD_LAST   = CW'(TIMEOUT - 1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]   level_q, level_d;
    logic [DW-1:0]   plaint_q, plaint_d;
    logic            in_vaild_q, in_vaild_d;
    logic [CW-1:0]   wd_cnt_q, wd_cnt_d;
    logic [15:0]     done_cnt_q, done_cnt_d;
    logic            tmo_q, tmo_d;
    logic            ovf_q, ovf_d;
    logic            push, pop;

    logic [DW-1:0]   mem [DEPTH];

    // Storage has no reset; only the pointers and level define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        plaint_d   = plaint_q;
        in_vaild_d = 1'b0;
        wd_cnt_d   = wd_cnt_q;
        done_cnt_d = done_cnt_q;
        tmo_d      = tmo_q;
        ovf_d      = ovf_q;
        pop        = 1'b0;
        push       = wr_en && !full;

        // Clear first so a same-cycle set event overrides it.
        if (err_clr) begin
            tmo_d = 1'b0;
            ovf_d = 1'b0;
        end
        if (wr_en && full) begin
            ovf_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (!empty && ready) begin
                    pop        = 1'b1;
                    plaint_d   = mem[rd_ptr_q];
                    in_vaild_d = 1'b1;
                    wd_cnt_d   = '0;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (vaild) begin
                    done_cnt_d = done_cnt_q + 16'd1;
                    state_d    = S_IDLE;
                end else if (wd_cnt_q == WD_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wd_cnt_d = wd_cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        unique case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            plaint_q   <= '0;
            in_vaild_q <= 1'b0;
            wd_cnt_q   <= '0;
            done_cnt_q <= '0;
            tmo_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            plaint_q   <= plaint_d;
            in_vaild_q <= in_vaild_d;
            wd_cnt_q   <= wd_cnt_d;
            done_cnt_q <= done_cnt_d;
            tmo_q      <= tmo_d;
            ovf_q      <= ovf_d;
        end
    end

    assign full        = (level_q == LVL_FULL);
    assign empty       = (level_q == '0);
    assign level       = level_q;
    assign plaint      = plaint_q;
    assign in_vaild    = in_vaild_q;
    assign busy        = (state_q == S_WAIT);
    assign done_cnt    = done_cnt_q;
    assign timeout_err = tmo_q;
    assign ovf_err     = ovf_q;

endmodule

// File: tb/tb_rsa_plain_feeder.sv
// Bench for rsa_plain_feeder: a queue-based reference model is compared against the DUT every cycle,
// and directed scenarios pin key results with hand-computed constants.
module tb_rsa_plain_feeder;

    localparam int DW    = 32;
    localparam int DEPTH = 8;
    localparam int TMO   = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           wr_en = 1'b0;
    logic [DW-1:0]  wr_data = '0;
    logic           full, empty, in_vaild, busy, timeout_err, ovf_err;
    logic [3:0]     level;
    logic [DW-1:0]  plaint;
    logic           ready = 1'b0;
    logic           vaild = 1'b0;
    logic [15:0]    done_cnt;
    logic           err_clr = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    rsa_plain_feeder #(.DW(DW), .DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .full(full), .empty(empty), .level(level), .plaint(plaint),
        .in_vaild(in_vaild), .ready(ready), .vaild(vaild), .busy(busy),
        .done_cnt(done_cnt), .timeout_err(timeout_err), .ovf_err(ovf_err),
        .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: the FIFO is a queue, the job timer counts cycles since dispatch.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_plaint = '0;
    logic [15:0]   m_done = '0;
    bit            m_busy = 0, m_inv = 0, m_tmo = 0, m_ovf = 0;
    bit            m_was_full, m_was_empty;
    int            m_age = 0;

    always @(posedge clk) begin
        if (reset) begin
            m_q.delete();
            m_plaint = '0; m_done = '0; m_busy = 0; m_inv = 0;
            m_tmo = 0; m_ovf = 0; m_age = 0;
        end else begin
            m_was_full  = (m_q.size() == DEPTH);
            m_was_empty = (m_q.size() == 0);
            if (err_clr) begin m_tmo = 0; m_ovf = 0; end
            m_inv = 0;
            if (!m_busy) begin
                if (!m_was_empty && ready) begin
                    m_plaint = m_q.pop_front();
                    m_inv = 1; m_busy = 1; m_age = 0;
                end
            end else begin
                m_age++;
                if (vaild) begin
                    m_done++; m_busy = 0;
                end else if (m_age == TMO) begin
                    m_tmo = 1; m_busy = 0;
                end
            end
            if (wr_en) begin
                if (m_was_full) m_ovf = 1;
                else m_q.push_back(wr_data);
            end
        end
        #1;
        chk("m_plaint",   plaint,      m_plaint);
        chk("m_in_vaild", in_vaild,    m_inv);
        chk("m_busy",     busy,        m_busy);
        chk("m_done_cnt", done_cnt,    m_done);
        chk("m_tmo_err",  timeout_err, m_tmo);
        chk("m_ovf_err",  ovf_err,     m_ovf);
        chk("m_level",    level,       m_q.size());
        chk("m_full",     full,        m_q.size() == DEPTH);
        chk("m_empty",    empty,       m_q.size() == 0);
    end

    // Core responder: answers each in_vaild with vaild sampled lat edges later (lat=0: never).
    int lat = 0;
    int cd = 0;
    bit vaild_man = 0;
    logic [DW-1:0] seen[$];

    task automatic cyc();
        @(posedge clk);
        #2;
        vaild = vaild_man;
        if (cd > 0) begin
            cd--;
            if (cd == 0) vaild = 1'b1;
        end
        if (in_vaild) begin
            seen.push_back(plaint);
            if (lat == 1) vaild = 1'b1;
            else if (lat > 1) cd = lat - 1;
        end
        if (reset) begin cd = 0; vaild = vaild_man; end
    endtask

    task automatic push1(input logic [DW-1:0] d);
        wr_en = 1'b1; wr_data = d;
        cyc();
        wr_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) cyc();
        chk("rst_empty", empty, 1);
        chk("rst_level", level, 0);
        chk("rst_done",  done_cnt, 0);
        reset = 1'b0;
        cyc();

        // Three jobs, each answered 12 cycles after its start pulse.
        ready = 1'b1; lat = 12;
        push1(32'd4); push1(32'd5); push1(32'd6);
        for (int i = 0; i < 200 && !(done_cnt == 16'd3 && !busy); i++) cyc();
        chk("t1_done", done_cnt, 3);
        chk("t1_empty", empty, 1);
        chk("t1_njobs", seen.size(), 3);
        chk("t1_p0", seen[0], 4);
        chk("t1_p1", seen[1], 5);
        chk("t1_p2", seen[2], 6);

        // Fill with the core not ready; the ninth word overflows.
        ready = 1'b0;
        for (int i = 0; i < 9; i++) push1(32'd100 + 32'(i));
        chk("t2_level", level, 8);
        chk("t2_full", full, 1);
        chk("t2_ovf", ovf_err, 1);
        err_clr = 1'b1; wr_en = 1'b1; wr_data = 32'hDEAD;
        cyc();
        wr_en = 1'b0;
        chk("t2_set_wins", ovf_err, 1);
        cyc();
        err_clr = 1'b0;
        chk("t2_cleared", ovf_err, 0);
        chk("t2_level_kept", level, 8);
        lat = 1; ready = 1'b1;
        for (int i = 0; i < 100 && !(empty && !busy); i++) cyc();
        chk("t2_done", done_cnt, 11);
        chk("t2_first", seen[3], 100);
        chk("t2_last", seen[10], 107);

        // Watchdog: first job is never answered.
        lat = 0;
        push1(32'd7);
        push1(32'd8);
        chk("t3_start", in_vaild, 1);
        repeat (15) cyc();
        chk("t3_tmo_early", timeout_err, 0);
        chk("t3_busy_early", busy, 1);
        cyc();
        chk("t3_tmo", timeout_err, 1);
        chk("t3_busy", busy, 0);
        chk("t3_done_same", done_cnt, 11);
        lat = 3;
        for (int i = 0; i < 50 && done_cnt != 16'd12; i++) cyc();
        chk("t3_next_done", done_cnt, 12);
        chk("t3_next_word", seen[seen.size()-1], 8);
        err_clr = 1'b1; cyc(); err_clr = 1'b0;
        chk("t3_clr", timeout_err, 0);

        // Completion on the final watchdog cycle wins.
        lat = 16;
        push1(32'd9);
        for (int i = 0; i < 100 && !(done_cnt == 16'd13 && !busy); i++) cyc();
        chk("t4_done", done_cnt, 13);
        chk("t4_no_tmo", timeout_err, 0);

        // vaild while idle is ignored.
        vaild_man = 1'b1; cyc(); vaild_man = 1'b0; cyc();
        chk("t5_idle_vaild", done_cnt, 13);

        // Reset mid-job with three words queued.
        lat = 0;
        push1(32'd10); push1(32'd11); push1(32'd12); push1(32'd13);
        repeat (3) cyc();
        chk("t6_busy", busy, 1);
        chk("t6_level", level, 3);
        reset = 1'b1;
        #1;
        chk("t6_r_busy", busy, 0);
        chk("t6_r_inv", in_vaild, 0);
        chk("t6_r_plaint", plaint, 0);
        chk("t6_r_done", done_cnt, 0);
        chk("t6_r_level", level, 0);
        chk("t6_r_empty", empty, 1);
        chk("t6_r_full", full, 0);
        chk("t6_r_errs", {timeout_err, ovf_err}, 0);
        cyc();
        reset = 1'b0;
        vaild_man = 1'b1; cyc(); vaild_man = 1'b0; cyc();
        chk("t6_late_vaild", done_cnt, 0);

        // Counter wrap from 0xFFFF.
        force dut.done_cnt_q = 16'hFFFF;
        m_done = 16'hFFFF;
        #1;
        release dut.done_cnt_q;
        cyc();
        chk("t7_preset", done_cnt, 16'hFFFF);
        lat = 2;
        push1(32'd20);
        for (int i = 0; i < 20 && !(done_cnt != 16'hFFFF && !busy); i++) cyc();
        chk("t7_wrap", done_cnt, 0);
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
